// File: rtl/conv_encoder_tx.sv
// Rate-1/2 feedforward convolutional encoder. Every frame is followed by K-1 zero
// tail bits so that the decoder trellis ends in state 0. Valid/ready on both sides.
module conv_encoder_tx #(
   parameter int           K  = 3,
   parameter logic [K-1:0] G0 = 3'b111,
   parameter logic [K-1:0] G1 = 3'b101
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_bit,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [1:0] sym_out,
   output logic       sym_valid,
   output logic       sym_last,
   input  logic       sym_ready,
   output logic       busy
);
   localparam int TW = $clog2(K);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_TAIL = 1'b1
   } state_t;

   // XOR reduction over the tapped register contents.
   function automatic logic parity_f(input logic [K-1:0] v);
      logic p;
      p = 1'b0;
      for (int i = 0; i < K; i++) begin
         p = p ^ v[i];
      end
      return p;
   endfunction

   state_t        state_q, state_d;
   logic [K-2:0]  sr_q, sr_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [1:0]    sym_q, sym_d;
   logic          sym_valid_q, sym_valid_d;
   logic          sym_last_q, sym_last_d;
   logic          busy_q, busy_d;
   logic          out_free_s;
   logic          in_ready_s;
   logic          enc_s;
   logic          u_s;
   logic [K-1:0]  d_s;

   assign out_free_s = !sym_valid_q || sym_ready;
   assign d_s        = {u_s, sr_q};

   // Next-state, encode step and handshake logic.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      sym_d       = sym_q;
      sym_valid_d = sym_valid_q && !sym_ready;
      sym_last_d  = sym_last_q;
      in_ready_s  = 1'b0;
      enc_s       = 1'b0;
      u_s         = 1'b0;

      case (state_q)
         ST_RUN: begin
            in_ready_s = out_free_s;
            if (in_valid && out_free_s) begin
               enc_s      = 1'b1;
               u_s        = in_bit;
               sym_last_d = 1'b0;
               if (in_last) begin
                  state_d = ST_TAIL;
                  cnt_d   = TW'(K - 1);
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               enc_s = 1'b0;
            end
         end
         ST_TAIL: begin
            if (out_free_s) begin
               enc_s = 1'b1;
               u_s   = 1'b0;
               cnt_d = cnt_q - TW'(1);
               // The last flush step leaves sr all-zero and closes the frame.
               if (cnt_q == TW'(1)) begin
                  sym_last_d = 1'b1;
                  state_d    = ST_RUN;
               end else begin
                  sym_last_d = 1'b0;
               end
            end else begin
               enc_s = 1'b0;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      if (enc_s) begin
         sym_d       = {parity_f(G0 & d_s), parity_f(G1 & d_s)};
         sym_valid_d = 1'b1;
         sr_d        = {u_s, sr_q[K-2:1]};
      end else begin
         sym_d = sym_q;
      end
   end

   assign busy_d = (state_d == ST_TAIL) || sym_valid_d;

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         sr_q        <= '0;
         cnt_q       <= '0;
         sym_q       <= 2'b00;
         sym_valid_q <= 1'b0;
         sym_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         sym_q       <= sym_d;
         sym_valid_q <= sym_valid_d;
         sym_last_q  <= sym_last_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign sym_out   = sym_q;
   assign sym_valid = sym_valid_q;
   assign sym_last  = sym_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Directed bench for conv_encoder_tx (K=3, G0=7, G1=5): hand-computed symbol
// sequences, handshake stalls, reset mid-frame, tail behaviour and random frames.
module tb_conv_encoder_tx;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_bit;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [1:0] sym_out;
   logic       sym_valid;
   logic       sym_last;
   logic       sym_ready;
   logic       busy;

   int         n_checks = 0;
   int         n_errs   = 0;
   int         acc_cnt  = 0;
   int         cyc      = 0;
   int         rdy_mode = 0;
   logic [5:0] rdy_pat  = 6'b101001;
   logic [2:0] got_q[$];
   logic [2:0] exp_q[$];

   logic       prev_stall = 1'b0;
   logic [1:0] prev_sym   = 2'b00;
   logic       prev_last  = 1'b0;

   conv_encoder_tx #(.K(3), .G0(3'b111), .G1(3'b101)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_bit   (in_bit),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_ready (in_ready),
      .sym_out  (sym_out),
      .sym_valid(sym_valid),
      .sym_last (sym_last),
      .sym_ready(sym_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Collect accepted symbols and bits; check that a stalled output holds.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall) begin
            n_checks++;
            assert (sym_valid === 1'b1 && sym_out === prev_sym && sym_last === prev_last) else begin
               n_errs++;
               $error("FAIL stall_hold got v=%0b s=%b l=%0b exp v=1 s=%b l=%0b",
                      sym_valid, sym_out, sym_last, prev_sym, prev_last);
            end
         end
         if (sym_valid && !sym_ready) begin
            n_checks++;
            assert (in_ready === 1'b0) else begin
               n_errs++;
               $error("FAIL stall_in_ready got %0b exp 0", in_ready);
            end
         end
         if (sym_valid && sym_ready) got_q.push_back({sym_last, sym_out});
         if (in_valid && in_ready) acc_cnt++;
         prev_stall = sym_valid && !sym_ready;
         prev_sym   = sym_out;
         prev_last  = sym_last;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errs++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
      case (rdy_mode)
         0:       sym_ready = 1'b1;
         1:       sym_ready = rdy_pat[cyc % 6];
         default: sym_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic send_bit(input logic b, input logic last);
      int w;
      in_valid = 1'b1;
      in_bit   = b;
      in_last  = last;
      w = 0;
      #1;
      while (!in_ready && w < 200) begin
         next_cycle();
         #1;
         w++;
      end
      chk("send_timeout", (w < 200) ? 32'd1 : 32'd0, 32'd1);
      next_cycle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_bit   = 1'b0;
   endtask

   task automatic drain_compare(input string tag);
      int w;
      w = 0;
      while (got_q.size() < exp_q.size() && w < 2000) begin
         next_cycle();
         w++;
      end
      repeat (3) next_cycle();
      chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) chk($sformatf("%s_sym%0d", tag, i), got_q[i], exp_q[i]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int   c1, c2, acc0, n;
      logic u, p1, p2;

      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; sym_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_sym_valid", sym_valid, 1'b0);
      chk("rst_sym_out", sym_out, 2'b00);
      chk("rst_sym_last", sym_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);

      // Frame 1,0,1,1 with continuous ready.
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
      #1;
      chk("t1_tail_rdy_a", in_ready, 1'b0);
      next_cycle(); #1;
      chk("t1_tail_rdy_b", in_ready, 1'b0);
      chk("t1_busy_tail", busy, 1'b1);
      next_cycle(); #1;
      chk("t1_rdy_back", in_ready, 1'b1);
      chk("t1_last_sym", sym_last, 1'b1);
      chk("t1_busy_last", busy, 1'b1);
      next_cycle(); #1;
      chk("t1_idle_valid", sym_valid, 1'b0);
      chk("t1_idle_busy", busy, 1'b0);
      exp_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
      drain_compare("t1");

      // Single-bit frame then an immediate back-to-back single-bit frame.
      send_bit(1'b1, 1'b1);
      c1 = cyc;
      send_bit(1'b0, 1'b1);
      c2 = cyc;
      chk("t2_b2b_gap", c2 - c1, 3);
      exp_q = '{3'b011, 3'b010, 3'b111, 3'b000, 3'b000, 3'b100};
      drain_compare("t2");

      // Same frame with sym_ready toggling 1,0,0,1,0,1.
      rdy_mode = 1;
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
      exp_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
      drain_compare("t3");
      rdy_mode = 0;
      next_cycle();

      // Reset after the second bit of frame 1,1,0,1.
      send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      #1;
      chk("t4_valid", sym_valid, 1'b0);
      chk("t4_busy", busy, 1'b0);
      chk("t4_in_ready", in_ready, 1'b1);
      got_q.delete();
      send_bit(1'b1, 1'b1);
      exp_q = '{3'b011, 3'b010, 3'b111};
      drain_compare("t4");

      // Random frames, random backpressure, against c0=u^p1^p2, c1=u^p2.
      rdy_mode = 2;
      for (int f = 0; f < 16; f++) begin
         n  = $urandom_range(1, 64);
         p1 = 1'b0;
         p2 = 1'b0;
         for (int i = 0; i < n + 2; i++) begin
            u = (i < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_q.push_back({(i == n + 1) ? 1'b1 : 1'b0, u ^ p1 ^ p2, u ^ p2});
            p2 = p1;
            p1 = u;
            if (i < n) send_bit(u, (i == n - 1) ? 1'b1 : 1'b0);
         end
      end
      drain_compare("t5");
      rdy_mode = 0;
      next_cycle();

      // in_valid/in_last held high during TAIL must not consume bits.
      acc0 = acc_cnt;
      send_bit(1'b1, 1'b0);
      in_valid = 1'b1; in_bit = 1'b0; in_last = 1'b1;
      next_cycle();
      in_bit = 1'b1;
      #1;
      chk("t6_rdy_a", in_ready, 1'b0);
      next_cycle(); #1;
      chk("t6_rdy_b", in_ready, 1'b0);
      next_cycle(); #1;
      chk("t6_rdy_c", in_ready, 1'b1);
      next_cycle();
      in_valid = 1'b0; in_last = 1'b0; in_bit = 1'b0;
      chk("t6_accepts", acc_cnt - acc0, 3);
      exp_q = '{3'b011, 3'b010, 3'b011, 3'b100, 3'b011, 3'b010, 3'b111};
      drain_compare("t6");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end
endmodule
